// File: rtl/counter_4bits_ctrl.sv
// Four-bit up/down/load counter driven by three debounced push buttons,
// with an optional auto-increment tick and a one-cycle wrap pulse.

module key_press #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic press
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic          level;
   logic [DW-1:0] cnt;

   // Level and synchronizers rest at 1 (released) so reset never yields a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1 <= 1'b1;
         sync_2 <= 1'b1;
         level  <= 1'b1;
         cnt    <= '0;
         press  <= 1'b0;
      end else begin
         sync_1 <= key_n;
         sync_2 <= sync_1;
         press  <= 1'b0;
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_2;
            cnt   <= '0;
            press <= ~sync_2;
         end else begin
            cnt <= cnt + DW'(1);
         end
      end
   end
endmodule

module counter_4bits_ctrl #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int TICK_CYCLES     = 50000000
) (
   input  logic       Clk,
   input  logic       Rst_n,
   input  logic       KeyUp_n,
   input  logic       KeyDown_n,
   input  logic       KeyLoad_n,
   input  logic [3:0] Sw,
   input  logic       AutoEn,
   output logic [3:0] Count,
   output logic       Wrap
);
   localparam int TW = $clog2(TICK_CYCLES);
   localparam logic [TW-1:0] PRESC_LAST = TW'(TICK_CYCLES - 1);

   logic          up_ev;
   logic          down_ev;
   logic          load_ev;
   logic          tick;
   logic [TW-1:0] presc;

   key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
      .clk(Clk), .rst_n(Rst_n), .key_n(KeyUp_n), .press(up_ev)
   );
   key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
      .clk(Clk), .rst_n(Rst_n), .key_n(KeyDown_n), .press(down_ev)
   );
   key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load (
      .clk(Clk), .rst_n(Rst_n), .key_n(KeyLoad_n), .press(load_ev)
   );

   // Prescaler parks at 0 while disabled, so the first tick is a full period away.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (!AutoEn) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (presc == PRESC_LAST) begin
         presc <= '0;
         tick  <= 1'b1;
      end else begin
         presc <= presc + TW'(1);
         tick  <= 1'b0;
      end
   end

   // Load beats keys, keys beat the tick; a tick lost to a key is not replayed.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Count <= 4'd0;
         Wrap  <= 1'b0;
      end else begin
         Wrap <= 1'b0;
         if (load_ev) begin
            Count <= Sw;
         end else if (up_ev && down_ev) begin
            Count <= Count;
         end else if (up_ev || (tick && !down_ev)) begin
            Count <= Count + 4'd1;
            Wrap  <= (Count == 4'd15);
         end else if (down_ev) begin
            Count <= Count - 4'd1;
            Wrap  <= (Count == 4'd0);
         end
      end
   end
endmodule

// File: tb/tb_counter_4bits_ctrl.sv
// Directed bench for counter_4bits_ctrl with short debounce/tick periods.

module tb_counter_4bits_ctrl;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_up_n = 1'b1;
   logic       key_down_n = 1'b1;
   logic       key_load_n = 1'b1;
   logic [3:0] sw = 4'h0;
   logic       auto_en = 1'b0;
   logic [3:0] count;
   logic       wrap;

   int n_cmp = 0;
   int n_err = 0;
   int wrap_total = 0;
   logic [3:0] exp_q[$];

   counter_4bits_ctrl #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(8)) dut (
      .Clk(clk), .Rst_n(rst_n), .KeyUp_n(key_up_n), .KeyDown_n(key_down_n),
      .KeyLoad_n(key_load_n), .Sw(sw), .AutoEn(auto_en), .Count(count), .Wrap(wrap)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200us;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   // counts every cycle the wrap pulse is high
   always @(negedge clk) if (wrap === 1'b1) wrap_total++;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // drivers
   task automatic press_keys(input logic up, input logic down, input logic load);
      @(negedge clk);
      key_up_n   = ~up;
      key_down_n = ~down;
      key_load_n = ~load;
      wait_cycles(12);
      key_up_n   = 1'b1;
      key_down_n = 1'b1;
      key_load_n = 1'b1;
      wait_cycles(12);
   endtask

   initial begin
      int w0;
      logic [3:0] model;

      wait_cycles(3);
      check_eq("reset_count", count, 4'd0);
      check_eq("reset_wrap", wrap, 1'b0);
      rst_n = 1'b1;
      wait_cycles(3);

      // bouncy up press: three 2-cycle glitches, then a solid hold
      w0 = wrap_total;
      for (int g = 0; g < 3; g++) begin
         key_up_n = 1'b0;
         wait_cycles(2);
         key_up_n = 1'b1;
         wait_cycles(3);
      end
      check_eq("glitch_no_event", count, 4'd0);
      key_up_n = 1'b0;
      wait_cycles(20);
      key_up_n = 1'b1;
      wait_cycles(12);
      check_eq("bounce_one_inc", count, 4'd1);
      check_eq("bounce_no_wrap", wrap_total - w0, 0);

      // load 15, wrap up, wrap down
      sw = 4'hF;
      press_keys(1'b0, 1'b0, 1'b1);
      check_eq("load_f", count, 4'hF);
      w0 = wrap_total;
      press_keys(1'b1, 1'b0, 1'b0);
      check_eq("up_wrap_count", count, 4'h0);
      check_eq("up_wrap_pulse", wrap_total - w0, 1);
      w0 = wrap_total;
      press_keys(1'b0, 1'b1, 1'b0);
      check_eq("down_wrap_count", count, 4'hF);
      check_eq("down_wrap_pulse", wrap_total - w0, 1);
      press_keys(1'b0, 1'b1, 1'b0);
      check_eq("down_plain", count, 4'hE);

      // auto increment from 0
      sw = 4'h0;
      press_keys(1'b0, 1'b0, 1'b1);
      check_eq("load_0", count, 4'h0);
      auto_en = 1'b1;
      wait_cycles(8);
      check_eq("auto_first_tick_pending", count, 4'd0);
      wait_cycles(1);
      check_eq("auto_first_inc", count, 4'd1);
      wait_cycles(31);
      check_eq("auto_before_5th", count, 4'd4);
      wait_cycles(1);
      check_eq("auto_40_cycles", count, 4'd5);
      auto_en = 1'b0;
      wait_cycles(20);
      check_eq("auto_frozen", count, 4'd5);

      // simultaneous keys
      press_keys(1'b1, 1'b1, 1'b0);
      check_eq("up_down_cancel", count, 4'd5);
      sw = 4'h7;
      press_keys(1'b1, 1'b0, 1'b1);
      check_eq("load_beats_up", count, 4'd7);

      // reset mid-debounce with count 9
      sw = 4'h9;
      press_keys(1'b0, 1'b0, 1'b1);
      check_eq("load_9", count, 4'd9);
      key_up_n = 1'b0;
      wait_cycles(4);
      #2 rst_n = 1'b0;
      #1 check_eq("async_reset", count, 4'd0);
      wait_cycles(2);
      rst_n = 1'b1;
      wait_cycles(2);
      key_up_n = 1'b1;
      wait_cycles(15);
      check_eq("no_event_after_reset", count, 4'd0);

      // up sweep through two wraps
      w0 = wrap_total;
      model = 4'd0;
      for (int p = 0; p < 32; p++) begin
         model = model + 4'd1;
         exp_q.push_back(model);
      end
      for (int p = 0; p < 32; p++) begin
         press_keys(1'b1, 1'b0, 1'b0);
         check_eq($sformatf("sweep_%0d", p), count, exp_q.pop_front());
      end
      check_eq("sweep_wraps", wrap_total - w0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
